gups_engine: RTL and testbench

GUPS_ENGINE -- requirements
Module: gups_engine

---
 rtl/gups_engine.sv | 153 +++++++++++++++
 tb/tb_gups_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gups_engine.sv
// ============================================================================
// Module   : gups_engine
// Purpose  : Random-access read-modify-write update engine (GUPS kernel).
//            Build macro GUPS_XOR_EN selects the XOR update instead of add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gups_engine #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int LFSR_W = 32,
    parameter int CNT_W  = 32,
    parameter int INC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic [ADDR_W-1:0] range,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  num_updates,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              req,
    output logic              wr,
    input  logic              rdy,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  upd_cnt
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_GEN  = 3'd1;
    localparam logic [2:0] c_RD   = 3'd2;
    localparam logic [2:0] c_MOD  = 3'd3;
    localparam logic [2:0] c_WR   = 3'd4;
    localparam logic [2:0] c_FIN  = 3'd5;

    localparam logic [LFSR_W-1:0] c_TAPS = LFSR_W'(32'h80200003);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_step;
    logic [LFSR_W-1:0] w_seed;
    logic [ADDR_W-1:0] r_range;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_lfsr_ext;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_mod;
    logic              w_last;

    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);
    assign w_seed      = (seed == 16'd0) ? LFSR_W'(1) : LFSR_W'(seed);
    assign w_last      = ((r_cnt + CNT_W'(1)) == r_num);

    // Zero-extend (or truncate) the stepped LFSR to the address width.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_ext
            if (gi < LFSR_W) begin : g_bit
                assign w_lfsr_ext[gi] = w_lfsr_step[gi];
            end else begin : g_zero
                assign w_lfsr_ext[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef GUPS_XOR_EN
    logic [DATA_W-1:0] w_lfsr_rep;

    generate
        for (genvar gj = 0; gj < DATA_W; gj++) begin : g_rep
            assign w_lfsr_rep[gj] = r_lfsr[gj % LFSR_W];
        end
    endgenerate

    assign w_mod = r_rdata ^ w_lfsr_rep;
`else
    assign w_mod = r_rdata + DATA_W'(INC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (start) w_next = c_GEN;
            c_GEN:  w_next = (r_num == '0) ? c_FIN : c_RD;
            c_RD:   if (rdy) w_next = c_MOD;
            c_MOD:  w_next = c_WR;
            c_WR:   if (rdy) w_next = w_last ? c_FIN : c_GEN;
            c_FIN:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr  <= LFSR_W'(1);
            r_range <= '0;
            r_base  <= '0;
            r_num   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_dout  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_lfsr  <= w_seed;
                        r_range <= range;
                        r_base  <= base;
                        r_num   <= num_updates;
                        r_cnt   <= '0;
                    end
                end
                c_GEN: begin
                    r_lfsr <= w_lfsr_step;
                    r_addr <= r_base + (w_lfsr_ext & r_range);
                end
                c_RD:  if (rdy) r_rdata <= din;
                c_MOD: r_dout <= w_mod;
                c_WR:  if (rdy) r_cnt <= r_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Handshake outputs decode straight from state so reset clears them at once.
    assign addr    = r_addr;
    assign dout    = r_dout;
    assign req     = (r_state == c_RD) || (r_state == c_WR);
    assign wr      = (r_state == c_WR);
    assign busy    = (r_state != c_IDLE);
    assign done    = (r_state == c_FIN);
    assign upd_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gups_engine.sv
// ============================================================================
// Module   : tb_gups_engine
// Purpose  : Directed self-checking bench for gups_engine with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gups_engine;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       seed = '0;
    logic [ADDR_W-1:0] range = '0;
    logic [ADDR_W-1:0] base = '0;
    logic [CNT_W-1:0]  num_updates = '0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              req;
    logic              wr;
    logic              rdy = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  upd_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem      [0:8191];
    logic [DATA_W-1:0] init_mem [0:8191];
    int                hits     [0:8191];

    logic [31:0]       m_lfsr;
    logic [ADDR_W-1:0] m_range;
    logic [ADDR_W-1:0] m_base;
    logic [63:0]       last_addr;
    logic [63:0]       last_dout;

    gups_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .range       (range),
        .base        (base),
        .num_updates (num_updates),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .req         (req),
        .wr          (wr),
        .rdy         (rdy),
        .busy        (busy),
        .done        (done),
        .upd_cnt     (upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [63:0] exp_mod(input logic [63:0] d, input logic [31:0] l);
`ifdef GUPS_XOR_EN
        return d ^ {l, l};
`else
        return d + 64'd1;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] s, input logic [63:0] r,
                             input logic [63:0] b, input logic [31:0] n);
        seed        = s;
        range       = r;
        base        = b;
        num_updates = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        m_lfsr      = (s == 16'd0) ? 32'd1 : {16'd0, s};
        m_range     = r;
        m_base      = b;
    endtask

    task automatic wait_req(input logic want_wr);
        for (int i = 0; i < 40; i++) begin
            if (req === 1'b1 && wr === want_wr) break;
            tick();
        end
    endtask

    // One read-modify-write transaction; optionally reset while the write waits.
    task automatic serve(input int rd_dly, input int wr_dly, input bit rst_in_wr);
        logic [63:0] a;
        logic [63:0] exp_d;
        int          idx;
        m_lfsr = lfsr_step(m_lfsr);
        a      = m_base + ({32'd0, m_lfsr} & m_range);
        idx    = int'(a[12:0]);
        wait_req(1'b0);
        chk("rd_req", {62'd0, req, wr}, 64'd2);
        chk("rd_addr", addr, a);
        chk("addr_in_range", {63'd0, (addr >= m_base) && (addr <= m_base + m_range)}, 64'd1);
        repeat (rd_dly) tick();
        chk("rd_addr_hold", addr, a);
        din = mem[idx];
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        din = {$urandom, $urandom};
        chk("mod_req", {63'd0, req}, 64'd0);
        exp_d = exp_mod(mem[idx], m_lfsr);
        wait_req(1'b1);
        chk("wr_req", {62'd0, req, wr}, 64'd3);
        chk("wr_addr", addr, a);
        chk("wr_dout", dout, exp_d);
        last_addr = addr;
        last_dout = dout;
        if (rst_in_wr) begin
            rst = 1'b1;
            #1;
            chk("rst_req", {63'd0, req}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_addr", addr, 64'd0);
            chk("rst_dout", dout, 64'd0);
            return;
        end
        repeat (wr_dly) tick();
        chk("wr_dout_hold", dout, exp_d);
        mem[idx] = dout;
        hits[idx]++;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("post_wr_req", {63'd0, req}, 64'd0);
    endtask

    initial begin
        int errs;
        int hsum;
        for (int i = 0; i < 8192; i++) begin
            mem[i]  = 64'hC0DE_0000_0000_0000 | 64'(i);
            hits[i] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("reset_req", {62'd0, req, wr}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        chk("reset_addr", addr, 64'd0);
        chk("reset_dout", dout, 64'd0);
        chk("reset_cnt", {32'd0, upd_cnt}, 64'd0);
        rst = 1'b0;
        tick();

        // Single update from seed 0: first address 0x3
`ifdef GUPS_XOR_EN
        mem[3] = 64'd0;
`else
        mem[3] = 64'h1234;
`endif
        start_run(16'd0, 64'h1fff, 64'd0, 32'd1);
        chk("run1_busy", {63'd0, busy}, 64'd1);
        serve(1, 1, 1'b0);
        chk("run1_addr", last_addr, 64'h3);
`ifdef GUPS_XOR_EN
        chk("run1_dout_xor", last_dout, 64'h8020000380200003);
`else
        chk("run1_dout", last_dout, 64'h1235);
`endif
        chk("run1_done", {62'd0, done, busy}, 64'd3);
        tick();
        chk("run1_after", {62'd0, done, busy}, 64'd0);
        chk("run1_cnt", {32'd0, upd_cnt}, 64'd1);

        // Zero updates: no request, done two edges after start accepted; stray rdy ignored
        rdy = 1'b1;
        start_run(16'd9, 64'h1fff, 64'd0, 32'd0);
        chk("zero_gen", {61'd0, busy, req, done}, 64'd4);
        tick();
        chk("zero_fin", {61'd0, busy, req, done}, 64'd5);
        num_updates = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rdy = 1'b0;
        chk("zero_idle", {61'd0, busy, req, done}, 64'd0);
        chk("zero_cnt", {32'd0, upd_cnt}, 64'd0);

        // All-ones read wraps to zero
        mem[16'h56] = '1;
        start_run(16'h00AB, 64'h1fff, 64'd0, 32'd1);
        serve(0, 0, 1'b0);
        chk("wrap_addr", last_addr, 64'h56);
`ifdef GUPS_XOR_EN
        chk("wrap_dout_xor", last_dout, 64'h7FDFFFA97FDFFFA9);
`else
        chk("wrap_dout", last_dout, 64'h0);
`endif
        tick();

        // Long run over a 256-word window with random memory latency
        for (int i = 0; i < 8192; i++) begin
            init_mem[i] = mem[i];
            hits[i]     = 0;
        end
        start_run(16'h1d2c, 64'hff, 64'h1000, 32'd1000);
        for (int k = 0; k < 1000; k++) begin
            if (k == 500) begin
                seed        = 16'h7777;
                base        = 64'd0;
                range       = 64'h1fff;
                num_updates = 32'd5;
                start       = 1'b1;
            end
            serve($urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
            start = 1'b0;
        end
        chk("long_done", {63'd0, done}, 64'd1);
        tick();
        chk("long_cnt", {32'd0, upd_cnt}, 64'd1000);
        chk("long_busy", {63'd0, busy}, 64'd0);
        errs = 0;
        hsum = 0;
        for (int i = 0; i < 8192; i++) begin
            hsum += hits[i];
`ifndef GUPS_XOR_EN
            if (mem[i] !== init_mem[i] + 64'(hits[i])) errs++;
`endif
        end
        chk("long_mem_errs", 64'(errs), 64'd0);
        chk("long_hits", 64'(hsum), 64'd1000);

        // Reset during the write wait abandons the update
        start_run(16'd5, 64'h1fff, 64'd0, 32'd3);
        serve(0, 0, 1'b1);
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("rst_rdy_ignored", {62'd0, busy, req}, 64'd0);
        chk("rst_cnt", {32'd0, upd_cnt}, 64'd0);
        start_run(16'd7, 64'h1fff, 64'd0, 32'd2);
        serve(0, 1, 1'b0);
        serve(2, 0, 1'b0);
        chk("rerun_done", {63'd0, done}, 64'd1);
        tick();
        chk("rerun_cnt", {32'd0, upd_cnt}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
